data_sync_tx: RTL and testbench

DATA_SYNC_TX -- requirements
Module: data_sync_tx

---
 rtl/data_sync_tx.sv | 109 ++++++++++
 tb/tb_data_sync_tx.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sync_tx.sv
// Source side of a bus-plus-enable clock domain crossing: holds a word on a
// registered bus and signals it with a level enable, closed by ack or fixed hold.
module data_sync_tx #(
    parameter int WIDTH   = 8,
    parameter int STAGES  = 2,
    parameter int USE_ACK = 1,
    parameter int HOLD    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] async_bus,
    output logic             bus_en,
    input  logic             ack_async,
    output logic             tx_done
);

    // Handshake: a word moves on a clk edge where in_valid and in_ready are
    // both high; in_valid while in_ready is low is dropped, never queued.

    localparam int CW = $clog2(HOLD + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SETUP = 2'd1;
    localparam logic [1:0] REQ   = 2'd2;
    localparam logic [1:0] REL   = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [CW-1:0]     cnt;
    logic [STAGES-1:0] ack_pipe;
    logic              ack_sync;
    logic              ack_ok;
    logic              accept;
    logic              hold_done;
    logic              req_exit;
    logic              rel_exit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_pipe <= '0;
        end else begin
            ack_pipe <= {ack_pipe[STAGES-2:0], ack_async};
        end
    end

    assign ack_sync  = ack_pipe[STAGES-1];
    assign ack_ok    = (USE_ACK == 0) || !ack_sync;
    assign in_ready  = (state == IDLE) && ack_ok && !rst;
    assign accept    = in_valid && in_ready;
    assign hold_done = (cnt == HOLD_LAST);

    // Ack mode waits on the synchronized ack level; fixed-hold mode on the counter.
    assign req_exit = (USE_ACK != 0) ? ack_sync  : hold_done;
    assign rel_exit = (USE_ACK != 0) ? !ack_sync : hold_done;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SETUP;
            SETUP:   state_nxt = REQ;
            REQ:     if (req_exit) state_nxt = REL;
            REL:     if (rel_exit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Counter restarts on each state change and saturates at HOLD-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (state_nxt != state) begin
            cnt <= '0;
        end else if ((state == REQ || state == REL) && !hold_done) begin
            cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            async_bus <= '0;
        end else if (accept) begin
            async_bus <= in_data;
        end
    end

    // Enable tracks REQ exactly, so it rises once per word, a cycle after the load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_en  <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            bus_en  <= (state_nxt == REQ);
            tx_done <= (state == REL) && (state_nxt == IDLE);
        end
    end

endmodule

// File: tb/tb_data_sync_tx.sv
// Directed bench for data_sync_tx: ack-mode, fixed-hold HOLD=4 and HOLD=1
// instances driven from one initial block with hand-computed expectations.
module tb_data_sync_tx;

    logic       clk;
    logic       rst;

    logic [7:0] a_data;
    logic       a_valid;
    logic       a_ready;
    logic [7:0] a_bus;
    logic       a_en;
    logic       a_ack;
    logic       a_done;

    logic [7:0] f_data;
    logic       f_valid;
    logic       f_ready;
    logic [7:0] f_bus;
    logic       f_en;
    logic       f_done;

    logic [7:0] b_data;
    logic       b_valid;
    logic       b_ready;
    logic [7:0] b_bus;
    logic       b_en;
    logic       b_done;

    logic       h_ack;

    int n_vec;
    int n_err;

    int a_done_cnt;
    int a_rise_cnt;
    int b_done_cnt;
    int b_rise_cnt;
    int f_pulses;
    logic [7:0] f_cap;
    logic a_en_q, b_en_q;
    logic d1, d2, d3;

    data_sync_tx #(.WIDTH(8), .STAGES(2), .USE_ACK(1), .HOLD(4)) u_ack (
        .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
        .async_bus(a_bus), .bus_en(a_en), .ack_async(a_ack), .tx_done(a_done)
    );

    data_sync_tx #(.WIDTH(8), .STAGES(2), .USE_ACK(0), .HOLD(4)) u_hold4 (
        .clk(clk), .rst(rst), .in_data(f_data), .in_valid(f_valid), .in_ready(f_ready),
        .async_bus(f_bus), .bus_en(f_en), .ack_async(h_ack), .tx_done(f_done)
    );

    data_sync_tx #(.WIDTH(8), .STAGES(2), .USE_ACK(0), .HOLD(1)) u_hold1 (
        .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
        .async_bus(b_bus), .bus_en(b_en), .ack_async(h_ack), .tx_done(b_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Event counters plus a small destination-side synchronizer model.
    initial begin
        a_done_cnt = 0; a_rise_cnt = 0; b_done_cnt = 0; b_rise_cnt = 0;
        f_pulses = 0; f_cap = 8'h00; a_en_q = 1'b0; b_en_q = 1'b0;
        d1 = 1'b0; d2 = 1'b0; d3 = 1'b0;
    end

    always @(posedge clk) begin
        if (a_done) a_done_cnt++;
        if (b_done) b_done_cnt++;
        if (a_en && !a_en_q) a_rise_cnt++;
        if (b_en && !b_en_q) b_rise_cnt++;
        a_en_q = a_en;
        b_en_q = b_en;
        d3 = d2;
        d2 = d1;
        d1 = f_en;
        if (d2 && !d3) begin
            f_pulses++;
            f_cap = f_bus;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Closes an ack-mode transfer that is sitting in REQ with bus_en high.
    task automatic ack_finish();
        a_ack = 1'b1;
        tick();
        tick();
        n_vec++; if (a_en !== 1'b1) begin n_err++; $display("FAIL ack_en_before_sync got %b want 1", a_en); end
        tick();
        n_vec++; if (a_en !== 1'b0) begin n_err++; $display("FAIL ack_en_drop got %b want 0", a_en); end
        a_ack = 1'b0;
        tick();
        tick();
        n_vec++; if (a_done !== 1'b0) begin n_err++; $display("FAIL ack_done_early got %b want 0", a_done); end
        tick();
        n_vec++; if (a_done !== 1'b1) begin n_err++; $display("FAIL ack_done_pulse got %b want 1", a_done); end
        n_vec++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL ack_ready_after got %b want 1", a_ready); end
        tick();
        n_vec++; if (a_done !== 1'b0) begin n_err++; $display("FAIL ack_done_width got %b want 0", a_done); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_vec++; if (a_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready got %b want 0", a_ready); end
        n_vec++; if (a_bus !== 8'h00) begin n_err++; $display("FAIL rst_bus got %h want 00", a_bus); end
        n_vec++; if (a_en !== 1'b0) begin n_err++; $display("FAIL rst_en got %b want 0", a_en); end
        n_vec++; if (a_done !== 1'b0) begin n_err++; $display("FAIL rst_done got %b want 0", a_done); end
        n_vec++; if (f_ready !== 1'b0) begin n_err++; $display("FAIL rst_hold_ready got %b want 0", f_ready); end
        rst = 1'b0;
        #1;
        n_vec++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL rel_ready got %b want 1", a_ready); end
        n_vec++; if (b_ready !== 1'b1) begin n_err++; $display("FAIL rel_hold_ready got %b want 1", b_ready); end
        tick();
    endtask

    task automatic test_ack_transfer();
        a_data = 8'hA5;
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        n_vec++; if (a_bus !== 8'hA5) begin n_err++; $display("FAIL xfer_bus got %h want a5", a_bus); end
        n_vec++; if (a_en !== 1'b0) begin n_err++; $display("FAIL xfer_setup_en got %b want 0", a_en); end
        n_vec++; if (a_ready !== 1'b0) begin n_err++; $display("FAIL xfer_setup_ready got %b want 0", a_ready); end
        tick();
        n_vec++; if (a_en !== 1'b1) begin n_err++; $display("FAIL xfer_en_rise got %b want 1", a_en); end
        tick();
        n_vec++; if (a_en !== 1'b1) begin n_err++; $display("FAIL xfer_en_hold got %b want 1", a_en); end
        ack_finish();
    endtask

    task automatic test_busy_reject();
        int rises0;
        rises0 = a_rise_cnt;
        a_data = 8'hA5;
        a_valid = 1'b1;
        tick();
        a_data = 8'hFF;
        tick();
        n_vec++; if (a_en !== 1'b1) begin n_err++; $display("FAIL busy_en got %b want 1", a_en); end
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (a_ready !== 1'b0) begin n_err++; $display("FAIL busy_ready got %b want 0", a_ready); end
            n_vec++; if (a_bus !== 8'hA5) begin n_err++; $display("FAIL busy_bus got %h want a5", a_bus); end
            tick();
        end
        a_valid = 1'b0;
        a_data = 8'h00;
        ack_finish();
        tick();
        tick();
        n_vec++; if (a_bus !== 8'hA5) begin n_err++; $display("FAIL idle_bus_hold got %h want a5", a_bus); end
        n_vec++; if (a_rise_cnt - rises0 !== 1) begin n_err++; $display("FAIL busy_rises got %0d want 1", a_rise_cnt - rises0); end
    endtask

    task automatic test_stale_ack();
        rst = 1'b1;
        a_ack = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        a_data = 8'h5A;
        a_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_vec++; if (a_ready !== 1'b0) begin n_err++; $display("FAIL stale_ready got %b want 0", a_ready); end
            n_vec++; if (a_bus !== 8'h00) begin n_err++; $display("FAIL stale_bus got %h want 00", a_bus); end
            tick();
        end
        a_ack = 1'b0;
        tick();
        n_vec++; if (a_ready !== 1'b0) begin n_err++; $display("FAIL stale_fall1_ready got %b want 0", a_ready); end
        n_vec++; if (a_bus !== 8'h00) begin n_err++; $display("FAIL stale_fall1_bus got %h want 00", a_bus); end
        tick();
        n_vec++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL stale_fall2_ready got %b want 1", a_ready); end
        tick();
        a_valid = 1'b0;
        n_vec++; if (a_bus !== 8'h5A) begin n_err++; $display("FAIL stale_accept_bus got %h want 5a", a_bus); end
        tick();
        n_vec++; if (a_en !== 1'b1) begin n_err++; $display("FAIL stale_en got %b want 1", a_en); end
        ack_finish();
    endtask

    task automatic test_reset_in_req();
        int done0;
        a_data = 8'h77;
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        tick();
        n_vec++; if (a_en !== 1'b1) begin n_err++; $display("FAIL rreq_en got %b want 1", a_en); end
        done0 = a_done_cnt;
        #2;
        rst = 1'b1;
        #1;
        n_vec++; if (a_en !== 1'b0) begin n_err++; $display("FAIL rreq_en_abort got %b want 0", a_en); end
        n_vec++; if (a_bus !== 8'h00) begin n_err++; $display("FAIL rreq_bus got %h want 00", a_bus); end
        n_vec++; if (a_ready !== 1'b0) begin n_err++; $display("FAIL rreq_ready got %b want 0", a_ready); end
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        n_vec++; if (a_done_cnt !== done0) begin n_err++; $display("FAIL rreq_no_done got %0d want %0d", a_done_cnt, done0); end
        n_vec++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL rreq_ready_after got %b want 1", a_ready); end
        a_data = 8'h11;
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        n_vec++; if (a_bus !== 8'h11) begin n_err++; $display("FAIL rreq_new_bus got %h want 11", a_bus); end
        tick();
        n_vec++; if (a_en !== 1'b1) begin n_err++; $display("FAIL rreq_new_en got %b want 1", a_en); end
        ack_finish();
    endtask

    task automatic test_fixed_hold();
        int pulses0;
        logic exp_en, exp_done;
        pulses0 = f_pulses;
        f_data = 8'h3C;
        f_valid = 1'b1;
        n_vec++; if (f_ready !== 1'b1) begin n_err++; $display("FAIL hold_ready got %b want 1", f_ready); end
        tick();
        f_valid = 1'b0;
        n_vec++; if (f_bus !== 8'h3C) begin n_err++; $display("FAIL hold_bus got %h want 3c", f_bus); end
        n_vec++; if (f_en !== 1'b0) begin n_err++; $display("FAIL hold_setup_en got %b want 0", f_en); end
        for (int i = 1; i <= 9; i++) begin
            tick();
            exp_en = (i <= 4);
            exp_done = (i == 9);
            n_vec++; if (f_en !== exp_en) begin n_err++; $display("FAIL hold_en cyc %0d got %b want %b", i, f_en, exp_en); end
            n_vec++; if (f_done !== exp_done) begin n_err++; $display("FAIL hold_done cyc %0d got %b want %b", i, f_done, exp_done); end
            n_vec++; if (f_ready !== exp_done) begin n_err++; $display("FAIL hold_ready cyc %0d got %b want %b", i, f_ready, exp_done); end
        end
        tick();
        n_vec++; if (f_done !== 1'b0) begin n_err++; $display("FAIL hold_done_width got %b want 0", f_done); end
        n_vec++; if (f_pulses - pulses0 !== 1) begin n_err++; $display("FAIL hold_en_pulses got %0d want 1", f_pulses - pulses0); end
        n_vec++; if (f_cap !== 8'h3C) begin n_err++; $display("FAIL hold_sync_bus got %h want 3c", f_cap); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [3];
        int done0, rises0;
        words[0] = 8'h01;
        words[1] = 8'h02;
        words[2] = 8'h03;
        done0 = b_done_cnt;
        rises0 = b_rise_cnt;
        b_data = words[0];
        b_valid = 1'b1;
        n_vec++; if (b_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready0 got %b want 1", b_ready); end
        for (int w = 0; w < 3; w++) begin
            tick();
            n_vec++; if (b_bus !== words[w]) begin n_err++; $display("FAIL b2b_bus w%0d got %h want %h", w, b_bus, words[w]); end
            n_vec++; if (b_ready !== 1'b0) begin n_err++; $display("FAIL b2b_busy w%0d got %b want 0", w, b_ready); end
            if (w < 2) b_data = words[w+1];
            else b_valid = 1'b0;
            tick();
            n_vec++; if (b_en !== 1'b1) begin n_err++; $display("FAIL b2b_en w%0d got %b want 1", w, b_en); end
            tick();
            n_vec++; if (b_en !== 1'b0) begin n_err++; $display("FAIL b2b_en_low w%0d got %b want 0", w, b_en); end
            tick();
            n_vec++; if (b_done !== 1'b1) begin n_err++; $display("FAIL b2b_done w%0d got %b want 1", w, b_done); end
            n_vec++; if (b_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready w%0d got %b want 1", w, b_ready); end
        end
        tick();
        n_vec++; if (b_done !== 1'b0) begin n_err++; $display("FAIL b2b_done_end got %b want 0", b_done); end
        n_vec++; if (b_bus !== 8'h03) begin n_err++; $display("FAIL b2b_bus_end got %h want 03", b_bus); end
        n_vec++; if (b_done_cnt - done0 !== 3) begin n_err++; $display("FAIL b2b_done_count got %0d want 3", b_done_cnt - done0); end
        n_vec++; if (b_rise_cnt - rises0 !== 3) begin n_err++; $display("FAIL b2b_rise_count got %0d want 3", b_rise_cnt - rises0); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        a_data = 8'h00; a_valid = 1'b0; a_ack = 1'b0;
        f_data = 8'h00; f_valid = 1'b0;
        b_data = 8'h00; b_valid = 1'b0;
        h_ack = 1'b1;
        test_reset();
        test_ack_transfer();
        test_busy_reject();
        test_stale_ack();
        test_reset_in_req();
        test_fixed_hold();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
